utmi_tx_t: RTL and testbench

//  - Downstream stage of the TX control mux: consumes the lp byte stream (sop/eop/valid/data/cancle, ready back-pressure) and drives a UTMI-style transmit port.
//  - First byte of each packet is the PID. For data PIDs it appends the inverted CRC16, low byte first.
//  - Enforces an inter-packet gap between packets.
//  - Reports packet done and abort events to the link layer.

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_crc16_byte.sv | 25 ++
 rtl/utmi_tx_t.sv | 204 ++++++++++++++++++++
 tb/tb_utmi_tx_t.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID values, CRC16 constants and TX FSM encoding.
// Pulled into the TX stage and the CRC16 byte helper.
package usb_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_DATA2 = 8'h87;
    localparam logic [7:0] PID_MDATA = 8'h0F;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_GAP
    } tx_state_e;

    function automatic logic pid_is_data(input logic [7:0] pid);
        logic r;
        unique case (pid[3:0])
            4'h3, 4'hB, 4'h7, 4'hF: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the reflected USB CRC16 (x^16+x^15+x^2+1).
// Purely combinational; data bits are consumed LSB first.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] next_crc
);

    logic [15:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC16_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        next_crc = c;
    end

endmodule

// File: rtl/utmi_tx_t.sv
// UTMI transmit stage: PID + payload + optional inverted CRC16, then IPG.
// CRC append is built only when UTMI_TX_T_CRC16_EN is defined.
module utmi_tx_t
    import usb_pkg::*;
#(
    parameter int IPG_CYCLES = 8
) (
    input  logic       i_utmi_tx_t_clk,
    input  logic       i_utmi_tx_t_rst_n,
    input  logic       i_utmi_tx_t_lp_sop,
    input  logic       i_utmi_tx_t_lp_eop,
    input  logic       i_utmi_tx_t_lp_valid,
    input  logic [7:0] i_utmi_tx_t_lp_data,
    input  logic       i_utmi_tx_t_lp_cancle,
    input  logic       i_utmi_tx_t_txready,
    output logic       o_utmi_tx_t_lp_ready,
    output logic       o_utmi_tx_t_txvalid,
    output logic [7:0] o_utmi_tx_t_dataout,
    output logic       o_utmi_tx_t_done,
    output logic       o_utmi_tx_t_abort,
    output logic       o_utmi_tx_t_busy
);

    localparam logic [7:0] GAP_LOAD = 8'(IPG_CYCLES - 1);

    tx_state_e   state_q, state_d;
    logic        txvalid_q, txvalid_d;
    logic [7:0]  dataout_q, dataout_d;
    logic        is_data_q, is_data_d;
    logic        last_q, last_d;
    logic [7:0]  gap_q, gap_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        run_q;

    logic        lp_ready;
    logic        lp_acc;
    logic        phy_acc;
    logic        cancle;
    logic        pid_data;
    logic [7:0]  crc_lo_b;
    logic [7:0]  crc_hi_b;

    assign cancle  = i_utmi_tx_t_lp_cancle;
    assign lp_ready = run_q & ((state_q == ST_IDLE) |
                     ((state_q == ST_DATA) &
                      (~txvalid_q | i_utmi_tx_t_txready)));
    assign lp_acc  = i_utmi_tx_t_lp_valid & lp_ready;
    assign phy_acc = txvalid_q & i_utmi_tx_t_txready;

`ifdef UTMI_TX_T_CRC16_EN
    logic [15:0] crc_q;
    logic [15:0] crc_upd;
    logic        ld_pid;
    logic        ld_byte;

    usb_crc16_byte u_crc (
        .crc      (crc_q),
        .data     (i_utmi_tx_t_lp_data),
        .next_crc (crc_upd)
    );

    assign ld_pid  = (state_q == ST_IDLE) & lp_acc & i_utmi_tx_t_lp_sop;
    assign ld_byte = (state_q == ST_DATA) & lp_acc & ~cancle & ~last_q;
    assign pid_data = pid_is_data(i_utmi_tx_t_lp_data);
    assign crc_lo_b = ~crc_q[7:0];
    assign crc_hi_b = ~crc_q[15:8];

    always_ff @(posedge i_utmi_tx_t_clk or negedge i_utmi_tx_t_rst_n) begin
        if (!i_utmi_tx_t_rst_n) begin
            crc_q <= CRC16_INIT;
        end else if (ld_pid) begin
            crc_q <= CRC16_INIT;
        end else if (ld_byte) begin
            crc_q <= crc_upd;
        end
    end
`else
    assign pid_data = 1'b0;
    assign crc_lo_b = 8'h00;
    assign crc_hi_b = 8'h00;
`endif

    always_comb begin
        state_d   = state_q;
        txvalid_d = txvalid_q;
        dataout_d = dataout_q;
        is_data_d = is_data_q;
        last_d    = last_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lp_acc && i_utmi_tx_t_lp_sop) begin
                    dataout_d = i_utmi_tx_t_lp_data;
                    txvalid_d = 1'b1;
                    is_data_d = pid_data;
                    last_d    = 1'b0;
                    state_d   = ST_DATA;
                    if (i_utmi_tx_t_lp_eop) begin
                        if (pid_data) state_d = ST_CRC_LO;
                        else          last_d  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (cancle) begin
                    txvalid_d = 1'b0;
                    abort_d   = 1'b1;
                    last_d    = 1'b0;
                    gap_d     = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (last_q) begin
                    // Bytes offered while the final byte drains are dropped.
                    if (phy_acc) begin
                        txvalid_d = 1'b0;
                        done_d    = 1'b1;
                        last_d    = 1'b0;
                        gap_d     = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end else if (lp_acc) begin
                    dataout_d = i_utmi_tx_t_lp_data;
                    txvalid_d = 1'b1;
                    if (i_utmi_tx_t_lp_eop) begin
                        if (is_data_q) state_d = ST_CRC_LO;
                        else           last_d  = 1'b1;
                    end
                end else if (phy_acc) begin
                    txvalid_d = 1'b0;
                end
            end
            ST_CRC_LO: begin
                if (cancle) begin
                    txvalid_d = 1'b0;
                    abort_d   = 1'b1;
                    gap_d     = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (phy_acc) begin
                    dataout_d = crc_lo_b;
                    state_d   = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                if (cancle) begin
                    txvalid_d = 1'b0;
                    abort_d   = 1'b1;
                    last_d    = 1'b0;
                    gap_d     = GAP_LOAD;
                    state_d   = ST_GAP;
                end else if (phy_acc) begin
                    if (last_q) begin
                        txvalid_d = 1'b0;
                        done_d    = 1'b1;
                        last_d    = 1'b0;
                        gap_d     = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        dataout_d = crc_hi_b;
                        last_d    = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_utmi_tx_t_clk or negedge i_utmi_tx_t_rst_n) begin
        if (!i_utmi_tx_t_rst_n) begin
            state_q   <= ST_IDLE;
            txvalid_q <= 1'b0;
            dataout_q <= 8'h00;
            is_data_q <= 1'b0;
            last_q    <= 1'b0;
            gap_q     <= 8'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            txvalid_q <= txvalid_d;
            dataout_q <= dataout_d;
            is_data_q <= is_data_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            run_q     <= 1'b1;
        end
    end

    assign o_utmi_tx_t_lp_ready = lp_ready;
    assign o_utmi_tx_t_txvalid  = txvalid_q;
    assign o_utmi_tx_t_dataout  = dataout_q;
    assign o_utmi_tx_t_done     = done_q;
    assign o_utmi_tx_t_abort    = abort_q;
    assign o_utmi_tx_t_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_utmi_tx_t.sv
// Scoreboard bench for utmi_tx_t; expectations follow UTMI_TX_T_CRC16_EN.
// Expected bytes are queued at stimulus time and popped on each PHY accept.
module tb_utmi_tx_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sop = 1'b0;
    logic       eop = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       cancle = 1'b0;
    logic       txready = 1'b1;
    logic       lp_ready;
    logic       txvalid;
    logic [7:0] dataout;
    logic       done;
    logic       abort;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int tx_cycles = 0;
    int bp_mode = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

`ifdef UTMI_TX_T_CRC16_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    utmi_tx_t #(.IPG_CYCLES(8)) dut (
        .i_utmi_tx_t_clk       (clk),
        .i_utmi_tx_t_rst_n     (rst_n),
        .i_utmi_tx_t_lp_sop    (sop),
        .i_utmi_tx_t_lp_eop    (eop),
        .i_utmi_tx_t_lp_valid  (valid),
        .i_utmi_tx_t_lp_data   (data),
        .i_utmi_tx_t_lp_cancle (cancle),
        .i_utmi_tx_t_txready   (txready),
        .o_utmi_tx_t_lp_ready  (lp_ready),
        .o_utmi_tx_t_txvalid   (txvalid),
        .o_utmi_tx_t_dataout   (dataout),
        .o_utmi_tx_t_done      (done),
        .o_utmi_tx_t_abort     (abort),
        .o_utmi_tx_t_busy      (busy)
    );

    always @(posedge clk) begin
        #1;
        cyc++;
        txready = (bp_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (abort) abort_cnt++;
            if (txvalid) tx_cycles++;
            if (prev_hold && txvalid) begin
                checks++;
                if (dataout !== prev_data) begin
                    errors++;
                    $display("FAIL hold: dataout %h required %h", dataout, prev_data);
                end
            end
            if (txvalid && !txready) begin
                checks++;
                if (lp_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_busy: lp_ready %b required 0", lp_ready);
                end
            end
            if (txvalid && txready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: dataout %h required none", dataout);
                end else begin
                    e = exp_q.pop_front();
                    if (dataout !== e) begin
                        errors++;
                        $display("FAIL byte: dataout %h required %h", dataout, e);
                    end
                end
            end
            prev_hold = txvalid && !txready;
            prev_data = dataout;
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic push_exp(input logic [7:0] p[$]);
        logic [15:0] c;
        logic [3:0]  lo;
        c = 16'hFFFF;
        for (int i = 0; i < p.size(); i++) begin
            exp_q.push_back(p[i]);
            if (i > 0) c = crc_step(c, p[i]);
        end
        lo = p[0][3:0];
        if (CRC_ON && (lo == 4'h3 || lo == 4'hB || lo == 4'h7 || lo == 4'hF)) begin
            exp_q.push_back(~c[7:0]);
            exp_q.push_back(~c[15:8]);
        end
    endtask

    task automatic send(input logic [7:0] p[$], input int cancel_at);
        int  n;
        bit  ok;
        @(posedge clk);
        #1;
        for (int i = 0; i < p.size(); i++) begin
            valid  = 1'b1;
            data   = p[i];
            sop    = (i == 0);
            eop    = (i == p.size() - 1);
            cancle = (i == cancel_at);
            n  = 0;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge clk);
                ok = lp_ready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL lp_timeout: byte %0d lp_ready 0 required 1", i);
            end
        end
        valid  = 1'b0;
        sop    = 1'b0;
        eop    = 1'b0;
        cancle = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int k;
        k = 0;
        while (done_cnt == prev && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == prev) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done count %0d required %0d", done_cnt, prev + 1);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic measure_gap(output int n, output logic v0, output logic a0);
        bit seen;
        seen = 1'b0;
        n = 0;
        v0 = 1'bx;
        a0 = 1'bx;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                v0 = txvalid;
                a0 = abort;
            end
            if (!lp_ready) begin
                seen = 1'b1;
                n++;
            end else if (seen) begin
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (txvalid !== 1'b0) begin errors++; $display("FAIL rst_txvalid: %b required 0", txvalid); end
        if (dataout !== 8'h00) begin errors++; $display("FAIL rst_dataout: %h required 00", dataout); end
        if (lp_ready !== 1'b0) begin errors++; $display("FAIL rst_lp_ready: %b required 0", lp_ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: %b required 0", done); end
        if (abort !== 1'b0) begin errors++; $display("FAIL rst_abort: %b required 0", abort); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack();
        logic [7:0] pkt[$];
        int d0, a0, n;
        logic v0, ab0;
        d0 = done_cnt;
        a0 = abort_cnt;
        pkt = {8'hD2};
        push_exp(pkt);
        send(pkt, -1);
        measure_gap(n, v0, ab0);
        checks += 4;
        if (n !== 8) begin errors++; $display("FAIL ack_gap: low clks %0d required 8", n); end
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ack_done: %0d required %0d", done_cnt - d0, 1); end
        if (abort_cnt !== a0) begin errors++; $display("FAIL ack_abort: %0d required 0", abort_cnt - a0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL ack_left: %0d required 0", exp_q.size()); end
    endtask

    task automatic test_empty_data0();
        logic [7:0] pkt[$];
        int d0, t0, want;
        d0 = done_cnt;
        t0 = tx_cycles;
        want = CRC_ON ? 3 : 1;
        pkt = {8'hC3};
        push_exp(pkt);
        send(pkt, -1);
        wait_done(d0);
        checks += 3;
        if (tx_cycles - t0 !== want) begin errors++; $display("FAIL d0_txvalid: clks %0d required %0d", tx_cycles - t0, want); end
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL d0_done: %0d required 1", done_cnt - d0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL d0_left: %0d required 0", exp_q.size()); end
    endtask

    task automatic run_data1(input string tag);
        logic [7:0] pkt[$];
        int d0;
        d0 = done_cnt;
        pkt = {8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
        if (CRC_ON) begin
            exp_q.push_back(8'hC8);
            exp_q.push_back(8'hB4);
        end
        send(pkt, -1);
        wait_done(d0);
        checks += 2;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL %s_done: %0d required 1", tag, done_cnt - d0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_left: %0d required 0", tag, exp_q.size()); end
    endtask

    task automatic test_data1();
        run_data1("data1");
    endtask

    task automatic test_backpressure();
        bp_mode = 1;
        run_data1("bp");
        bp_mode = 0;
    endtask

    task automatic test_cancel();
        logic [7:0] pkt[$];
        int d0, a0, n;
        logic v0, ab0;
        d0 = done_cnt;
        a0 = abort_cnt;
        pkt = {8'h4B, 8'h31, 8'h32, 8'h33};
        for (int i = 0; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
        pkt.push_back(8'h34);
        send(pkt, 4);
        measure_gap(n, v0, ab0);
        repeat (2) @(negedge clk);
        #1;
        checks += 6;
        if (v0 !== 1'b0) begin errors++; $display("FAIL cancel_txvalid: %b required 0", v0); end
        if (ab0 !== 1'b1) begin errors++; $display("FAIL cancel_abort: %b required 1", ab0); end
        if (n !== 8) begin errors++; $display("FAIL cancel_gap: low clks %0d required 8", n); end
        if (abort_cnt !== a0 + 1) begin errors++; $display("FAIL cancel_abort_cnt: %0d required 1", abort_cnt - a0); end
        if (done_cnt !== d0) begin errors++; $display("FAIL cancel_done: %0d required 0", done_cnt - d0); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL cancel_left: %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pkt[$];
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        pkt = {8'h4B, 8'h31, 8'h32};
        for (int i = 0; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
        send(pkt, -1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 9;
        if (txvalid !== 1'b0) begin errors++; $display("FAIL mrst_txvalid: %b required 0", txvalid); end
        if (dataout !== 8'h00) begin errors++; $display("FAIL mrst_dataout: %h required 00", dataout); end
        if (lp_ready !== 1'b0) begin errors++; $display("FAIL mrst_lp_ready: %b required 0", lp_ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: %b required 0", done); end
        if (abort !== 1'b0) begin errors++; $display("FAIL mrst_abort: %b required 0", abort); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: %b required 0", busy); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mrst_left: %0d required 0", exp_q.size()); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        if (done_cnt !== d0) begin errors++; $display("FAIL mrst_no_done: %0d required 0", done_cnt - d0); end
        if (abort_cnt !== a0) begin errors++; $display("FAIL mrst_no_abort: %0d required 0", abort_cnt - a0); end
        repeat (2) @(negedge clk);
        run_data1("post_rst");
    endtask

    task automatic test_short();
        logic [7:0] pkt[$];
        int d0, t0, want;
        d0 = done_cnt;
        t0 = tx_cycles;
        want = CRC_ON ? 5 : 3;
        pkt = {8'h4B, 8'h31, 8'h32};
        push_exp(pkt);
        send(pkt, -1);
        wait_done(d0);
        checks += 2;
        if (tx_cycles - t0 !== want) begin errors++; $display("FAIL short_len: clks %0d required %0d", tx_cycles - t0, want); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL short_left: %0d required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_empty_data0();
        test_data1();
        test_backpressure();
        test_cancel();
        test_reset_mid();
        test_short();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
